// File: rtl/int_injector.sv
// int_injector: raises per-channel interrupts when the CPU PC reaches a programmed
// target, holding each line until an acknowledge store or an optional timeout.
module int_injector #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TMO_W    = 16,
  parameter logic [31:0] ACK_BASE = 32'h0000_7f20,
  parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [31:0]         cfg_target_pc,
  input  logic [CNT_W-1:0]    cfg_count,
  input  logic [TMO_W-1:0]    cfg_timeout,
  input  logic [31:0]         macroscopic_pc,
  input  logic [31:0]         m_int_addr,
  input  logic [3:0]          m_int_byteen,
  output logic [CHANNELS-1:0] interrupt,
  output logic                irq_any,
  output logic [CHANNELS-1:0] active,
  output logic [CHANNELS-1:0] timeout_flag
);

  typedef enum logic [1:0] {StIdle, StArmed, StPending, StWaitLeave} state_e;

  state_e           state   [CHANNELS];
  logic [29:0]      tgt     [CHANNELS];
  logic [CNT_W-1:0] remain  [CHANNELS];
  logic [TMO_W-1:0] tmo_cfg [CHANNELS];
  logic [TMO_W-1:0] tmo_cnt [CHANNELS];

  logic [CHANNELS-1:0] pc_hit;
  logic [CHANNELS-1:0] ack;
  logic [CHANNELS-1:0] cfg_sel;
  logic [CHANNELS-1:0] tmo_expire;

  // Byte-address bits [1:0] never take part in matching.
  logic unused_low_bits;
  assign unused_low_bits = ^{cfg_target_pc[1:0], macroscopic_pc[1:0], m_int_addr[1:0]};

  // Word address of channel k's acknowledge location.
  function automatic logic [29:0] ack_word(input int unsigned k);
    logic [31:0] a;
    a = ACK_BASE + 32'(4 * k);
    return a[31:2];
  endfunction

  // Decode per-channel target hit, ack store, config select and timeout expiry
  always_comb begin
    pc_hit     = '0;
    ack        = '0;
    cfg_sel    = '0;
    tmo_expire = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      pc_hit[k]     = (macroscopic_pc[31:2] == tgt[k]);
      ack[k]        = (|m_int_byteen) && (m_int_addr[31:2] == ack_word(k));
      // Out-of-range channel numbers match no k and are dropped here.
      cfg_sel[k]    = cfg_we && (32'(cfg_ch) == k);
      tmo_expire[k] = (tmo_cfg[k] != '0) && (tmo_cnt[k] == TMO_W'(1));
    end
  end

  // Per-channel FSM: config write > ack > timeout > pc_hit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        state[k]   <= StIdle;
        tgt[k]     <= '0;
        remain[k]  <= '0;
        tmo_cfg[k] <= '0;
        tmo_cnt[k] <= '0;
      end
      interrupt    <= '0;
      timeout_flag <= '0;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (cfg_sel[k]) begin
          tgt[k]          <= cfg_target_pc[31:2];
          remain[k]       <= cfg_count;
          tmo_cfg[k]      <= cfg_timeout;
          timeout_flag[k] <= 1'b0;
          interrupt[k]    <= 1'b0;
          state[k]        <= (cfg_count != '0) ? StArmed : StIdle;
        end else begin
          unique case (state[k])
            StIdle: begin
            end
            StArmed: begin
              if (pc_hit[k]) begin
                state[k]     <= StPending;
                interrupt[k] <= 1'b1;
                remain[k]    <= remain[k] - CNT_W'(1);
                tmo_cnt[k]   <= tmo_cfg[k];
              end
            end
            StPending: begin
              if (ack[k] || tmo_expire[k]) begin
                interrupt[k] <= 1'b0;
                state[k]     <= (remain[k] == '0) ? StIdle : StWaitLeave;
                if (!ack[k]) timeout_flag[k] <= 1'b1;
              end else if (tmo_cfg[k] != '0) begin
                tmo_cnt[k] <= tmo_cnt[k] - TMO_W'(1);
              end
            end
            StWaitLeave: begin
              // Re-arm only once the PC has left the target, so one dwell fires once.
              if (!pc_hit[k]) state[k] <= StArmed;
            end
            default: state[k] <= StIdle;
          endcase
        end
      end
    end
  end

  // Status outputs derived directly from registered state
  always_comb begin
    irq_any = |interrupt;
    active  = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      active[k] = (state[k] != StIdle);
    end
  end

endmodule

// File: tb/tb_int_injector.sv
// tb_int_injector: directed and randomized checks of int_injector against a
// firing-count / high-time reference model.
module tb_int_injector;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_target_pc;
  logic [7:0]  cfg_count;
  logic [15:0] cfg_timeout;
  logic [31:0] macroscopic_pc;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic [3:0]  interrupt;
  logic        irq_any;
  logic [3:0]  active;
  logic [3:0]  timeout_flag;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: firings left, whether the line is up, how long it has been up,
  // and whether the PC must leave the target before another firing.
  logic [31:0] m_tgt   [NCH];
  int          m_left  [NCH];
  int          m_tmo   [NCH];
  bit          m_pend  [NCH];
  bit          m_block [NCH];
  bit          m_tflag [NCH];
  int          m_high  [NCH];

  int         rise_cnt [NCH];
  int         high_cnt [NCH];
  logic [3:0] prev_irq;

  int_injector dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_we         (cfg_we),
    .cfg_ch         (cfg_ch),
    .cfg_target_pc  (cfg_target_pc),
    .cfg_count      (cfg_count),
    .cfg_timeout    (cfg_timeout),
    .macroscopic_pc (macroscopic_pc),
    .m_int_addr     (m_int_addr),
    .m_int_byteen   (m_int_byteen),
    .interrupt      (interrupt),
    .irq_any        (irq_any),
    .active         (active),
    .timeout_flag   (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_tgt[k] = '0; m_left[k] = 0; m_tmo[k] = 0; m_pend[k] = 0;
      m_block[k] = 0; m_tflag[k] = 0; m_high[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NCH; k++) begin
      bit hit, ak;
      logic [31:0] ack_at;
      ack_at = 32'h0000_7f20 + 32'(4 * k);
      hit = ((macroscopic_pc & ~32'h3) == m_tgt[k]);
      ak  = (m_int_byteen != 0) && ((m_int_addr >> 2) == (ack_at >> 2));
      if (cfg_we && int'(cfg_ch) == k) begin
        m_tgt[k] = cfg_target_pc & ~32'h3;
        m_left[k] = int'(cfg_count);
        m_tmo[k] = int'(cfg_timeout);
        m_pend[k] = 0; m_block[k] = 0; m_tflag[k] = 0;
      end else if (m_pend[k]) begin
        if (ak) begin
          m_pend[k] = 0; m_block[k] = 1;
        end else if (m_tmo[k] != 0 && m_high[k] + 1 == m_tmo[k]) begin
          m_pend[k] = 0; m_block[k] = 1; m_tflag[k] = 1;
        end else begin
          m_high[k]++;
        end
      end else if (m_left[k] > 0) begin
        if (m_block[k]) begin
          if (!hit) m_block[k] = 0;
        end else if (hit) begin
          m_pend[k] = 1; m_left[k]--; m_high[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] e_irq, e_act, e_tf;
    for (int k = 0; k < NCH; k++) begin
      e_irq[k] = m_pend[k];
      e_act[k] = m_pend[k] || (m_left[k] > 0);
      e_tf[k]  = m_tflag[k];
    end
    check("interrupt", 32'(interrupt), 32'(e_irq));
    check("irq_any", 32'(irq_any), 32'(|e_irq));
    check("active", 32'(active), 32'(e_act));
    check("timeout_flag", 32'(timeout_flag), 32'(e_tf));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    compare_all();
    for (int k = 0; k < NCH; k++) begin
      if (interrupt[k] && !prev_irq[k]) rise_cnt[k]++;
      if (interrupt[k]) high_cnt[k]++;
    end
    prev_irq = interrupt;
  endtask

  task automatic do_cfg(input int ch, input logic [31:0] tpc, input int cnt, input int tmo);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_target_pc = tpc;
    cfg_count = 8'(cnt); cfg_timeout = 16'(tmo);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_ack(input int ch);
    m_int_addr = 32'h0000_7f20 + 32'(4 * ch); m_int_byteen = 4'hf;
    tick();
    m_int_byteen = 4'h0;
  endtask

  task automatic set_pc(input logic [31:0] pc, input int n);
    macroscopic_pc = pc;
    repeat (n) tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; cfg_we = 0; cfg_ch = 0; cfg_target_pc = 0; cfg_count = 0; cfg_timeout = 0;
    macroscopic_pc = 32'h1000; m_int_addr = 0; m_int_byteen = 0;
    prev_irq = '0;
    for (int k = 0; k < NCH; k++) begin rise_cnt[k] = 0; high_cnt[k] = 0; end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    reset = 1'b0;

    // One-shot on ch0
    do_cfg(0, 32'h3010, 1, 0);
    set_pc(32'h3010, 1);
    check("oneshot_fire", 32'(interrupt[0]), 1);
    macroscopic_pc = 32'h1000;
    do_ack(0);
    check("oneshot_ack", 32'(interrupt[0]), 0);
    check("oneshot_idle", 32'(active[0]), 0);
    set_pc(32'h3010, 2);
    check("oneshot_nofire", 32'(interrupt[0]), 0);
    set_pc(32'h1000, 1);

    // Repeat with dwell on ch1
    rise_cnt[1] = 0;
    do_cfg(1, 32'h3020, 3, 0);
    set_pc(32'h3020, 1);
    do_ack(1);
    set_pc(32'h3020, 5);
    check("dwell_norefire", 32'(rise_cnt[1]), 1);
    set_pc(32'h1000, 1);
    set_pc(32'h3020, 1);
    check("dwell_second", 32'(rise_cnt[1]), 2);
    do_ack(1);
    set_pc(32'h1000, 1);
    set_pc(32'h3020, 1);
    do_ack(1);
    set_pc(32'h1000, 1);
    set_pc(32'h3020, 3);
    set_pc(32'h1000, 1);
    check("dwell_total", 32'(rise_cnt[1]), 3);
    check("dwell_idle", 32'(active[1]), 0);

    // Timeout on ch2
    high_cnt[2] = 0;
    do_cfg(2, 32'h3030, 1, 4);
    set_pc(32'h3030, 1);
    set_pc(32'h1000, 8);
    check("tmo_high_cycles", 32'(high_cnt[2]), 4);
    check("tmo_flag", 32'(timeout_flag[2]), 1);
    do_cfg(2, 32'h3030, 0, 0);
    check("tmo_flag_clr", 32'(timeout_flag[2]), 0);

    // Ack coinciding with timeout expiry on ch2
    do_cfg(2, 32'h3030, 1, 4);
    set_pc(32'h3030, 1);
    set_pc(32'h1000, 3);
    do_ack(2);
    check("coll_ack_irq", 32'(interrupt[2]), 0);
    check("coll_ack_flag", 32'(timeout_flag[2]), 0);

    // Config write and ack together on ch1
    do_cfg(1, 32'h3040, 1, 0);
    set_pc(32'h3040, 1);
    macroscopic_pc = 32'h1000;
    check("coll_cfg_pre", 32'(interrupt[1]), 1);
    m_int_addr = 32'h7f24; m_int_byteen = 4'hf;
    do_cfg(1, 32'h3050, 2, 0);
    m_int_byteen = 4'h0;
    check("coll_cfg_irq", 32'(interrupt[1]), 0);
    check("coll_cfg_armed", 32'(active[1]), 1);
    do_cfg(1, 32'h0, 0, 0);

    // Multi-channel shared target
    do_cfg(0, 32'h3000, 1, 0);
    do_cfg(3, 32'h3000, 1, 0);
    set_pc(32'h3000, 1);
    macroscopic_pc = 32'h1000;
    check("multi_both", 32'(interrupt), 32'h9);
    check("multi_any", 32'(irq_any), 1);
    do_ack(3);
    check("multi_ack3", 32'(interrupt), 32'h1);
    do_cfg(3, 32'h3000, 1, 0);
    set_pc(32'h3000, 1);
    macroscopic_pc = 32'h1000;
    m_int_addr = 32'h7f2e; m_int_byteen = 4'b0100;
    tick();
    m_int_byteen = 4'h0;
    check("multi_misaligned", 32'(interrupt), 32'h1);

    // Asynchronous reset while ch0 pending
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("rst_irq", 32'(interrupt), 0);
    check("rst_any", 32'(irq_any), 0);
    check("rst_active", 32'(active), 0);
    check("rst_tflag", 32'(timeout_flag), 0);
    @(negedge clk);
    reset = 1'b0;
    prev_irq = interrupt;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int r;
      if ($urandom_range(0, 1) == 0) begin
        r = int'($urandom_range(0, 5));
        macroscopic_pc = (r < 4) ? 32'h3000 + 32'(4 * r) + 32'($urandom_range(0, 3))
                                 : 32'h2000;
      end
      cfg_we = ($urandom_range(0, 15) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_target_pc = 32'h3000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      cfg_count = 8'($urandom_range(0, 3));
      cfg_timeout = 16'($urandom_range(0, 6));
      r = int'($urandom_range(0, 7));
      m_int_addr = 32'h7f20 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      if (r < 3) m_int_byteen = 4'($urandom_range(1, 15));
      else if (r == 4) begin
        m_int_addr = 32'h7f30;
        m_int_byteen = 4'hf;
      end else m_int_byteen = 4'h0;
      tick();
    end
    cfg_we = 1'b0;
    m_int_byteen = 4'h0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_injector.md
# int_injector

Parametrised, synthesizable interrupt-stimulus generator for the pipelined MIPS CPU bench. It watches the CPU's macroscopic PC and raises one of `CHANNELS` interrupt lines when a programmed target PC is reached. Each line stays high until the handler acknowledges it by storing to that channel's acknowledge word, or until an optional timeout expires. A channel can fire a programmed number of times. It sits beside the CPU in the bench/SoC top, driving `interrupt` and snooping the CPU's `m_int_addr`/`m_int_byteen` port.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent interrupt channels (1..8).
- `CNT_W`, 8: width of the per-channel fire count.
- `TMO_W`, 16: width of the per-channel timeout.
- `ACK_BASE`, 32'h0000_7f20: acknowledge word of channel 0; channel k uses `ACK_BASE + 4*k`.

Ports:
- `clk`  in  1  single clock, all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_ch`  in  $clog2(CHANNELS) (min 1)  channel selected by the write.
- `cfg_target_pc`  in  32  target PC; bits [1:0] are ignored.
- `cfg_count`  in  CNT_W  number of firings; 0 disarms the channel.
- `cfg_timeout`  in  TMO_W  maximum high time in cycles; 0 means wait for ack forever.
- `macroscopic_pc`  in  32  CPU macroscopic PC.
- `m_int_addr`  in  32  CPU store address (interrupt-ack port).
- `m_int_byteen`  in  4  CPU store byte enables.
- `interrupt`  out  CHANNELS  per-channel interrupt request, registered.
- `irq_any`  out  1  OR of `interrupt`.
- `active`  out  CHANNELS  channel is not in IDLE.
- `timeout_flag`  out  CHANNELS  sticky: the channel's last firing ended by timeout.

## Operation
- Per-channel FSM with states IDLE, ARMED, PENDING, WAIT_LEAVE.
- Per-channel state: `tgt` (30 bits), `remain` (CNT_W), `tmo_cfg` and `tmo_cnt` (TMO_W).
- `pc_hit[k]` = (`macroscopic_pc[31:2]` == `tgt[k]`).
- `ack[k]` = `|m_int_byteen` and `m_int_addr[31:2]` == (`ACK_BASE + 4*k`)[31:2].
- Config write to channel k:
  - Loads `tgt`, `remain`, `tmo_cfg`.
  - Clears `timeout_flag[k]` and drops `interrupt[k]`.
  - Next state is ARMED if `cfg_count` != 0, else IDLE.
  - A write to an out-of-range `cfg_ch` is ignored.
- IDLE: holds; only a config write leaves it.
- ARMED, on `pc_hit`:
  - Go to PENDING, set `interrupt[k]`, `remain` -= 1.
  - Load `tmo_cnt` = `tmo_cfg`.
- PENDING, on `ack`:
  - Clear `interrupt[k]`.
  - Go to IDLE if `remain` == 0, else WAIT_LEAVE.
- PENDING, timeout (`tmo_cfg` != 0 and `tmo_cnt` == 1, no `ack`):
  - Same exit as ack, and set `timeout_flag[k]`.
  - Otherwise, when `tmo_cfg` != 0, `tmo_cnt` decrements each cycle in PENDING.
- WAIT_LEAVE: go to ARMED in the first cycle `pc_hit` is false. This prevents re-firing on the same dwell at the target.
- Priority for a channel in one cycle: config write > ack > timeout > pc_hit.
- Channels are fully independent. Several may fire or be acked in the same cycle.
- An ack to a channel that is not PENDING has no effect.

## Timing
- Reset (asynchronous): all FSMs IDLE; `interrupt`, `irq_any`, `active`, `timeout_flag` = 0; all counters 0.
- Fire latency: `pc_hit` sampled at edge N → `interrupt[k]` high after edge N (1 cycle).
- Ack latency: ack store present at edge N → `interrupt[k]` low after edge N.
- Timeout: with `tmo_cfg` = T and no ack, `interrupt[k]` is high for exactly T cycles.
- `irq_any`, `active`, `timeout_flag` are combinational from registered state and carry no extra latency.
- `remain` never underflows: it is decremented only on entry to PENDING, which requires ARMED, and ARMED requires `remain` ≥ 1.
- Reset mid-PENDING drops `interrupt` immediately, without waiting for a clock edge.

## Test plan
- One-shot: ch0 target 0x3010, count 1, timeout 0; PC reaches 0x3010 → `interrupt[0]`=1 the next cycle. Store to 0x7f20 → 0 the next cycle, `active[0]`=0. A second visit to 0x3010 gives no fire.
- Repeat with dwell: ch1 target 0x3020, count 3; PC held at 0x3020 for 5 cycles after the ack of the first firing → no refire. PC leaves then returns → second firing. Exactly 3 firings in total, then IDLE.
- Timeout: ch2 count 1, timeout 4, no ack → `interrupt[2]` high exactly 4 cycles, `timeout_flag[2]`=1. A config write to ch2 clears the flag.
- Collision: ack and timeout expiry in the same cycle on ch2 → counted as ack, `timeout_flag[2]` stays 0. Config write and ack in the same cycle on ch1 → config wins, ch1 ARMED.
- Multi-channel: ch0 and ch3 share target 0x3000 → both fire in the same cycle, `irq_any`=1. An ack to 0x7f2c clears only ch3. A misaligned store to 0x7f2e with byteen=4'b0100 also acks ch3.
- Async reset asserted mid-cycle while ch0 is PENDING → `interrupt`=0 before the next clock edge, all outputs 0.
